// File: rtl/iob_alarm_core.sv
// iob_alarm_core: programmable countdown alarm.
//
// Software loads a tick count, a prescale divider and a mode. After
// (prescale+1)*count enabled cycles the core raises a sticky irq_o.
// In periodic mode the count reloads with no gap. An expiry that
// arrives while irq_o is still pending sets the sticky overrun_o.
//
// Ports:
//   clk_i       system clock
//   arst_n_i    asynchronous active-low reset
//   cke_i       clock enable; 0 freezes every register
//   en_i        count enable; 0 pauses prescaler and countdown
//   load_i      strobe: capture load_val_i/prescale_i/periodic_i, (re)start
//   load_val_i  ticks to expiry (0 raises irq_o at once without running)
//   prescale_i  divider minus one
//   periodic_i  1 = auto-reload, 0 = one-shot
//   ack_i       strobe: clear irq_o and overrun_o
//   count_o     remaining ticks
//   busy_o      high while running
//   irq_o       sticky expiry flag
//   overrun_o   sticky expiry-while-pending flag
module iob_alarm_core #(
  parameter int DATA_W     = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     load_val_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  periodic_i,
  input  logic                  ack_i,
  output logic [DATA_W-1:0]     count_o,
  output logic                  busy_o,
  output logic                  irq_o,
  output logic                  overrun_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [DATA_W-1:0]     CNT_ONE = DATA_W'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]       reload_q, reload_d;
  logic [PRESCALE_W-1:0]   psc_lim_q, psc_lim_d;
  logic [PRESCALE_W-1:0]   psc_cnt_q, psc_cnt_d;
  logic                    periodic_q, periodic_d;
  logic                    irq_q, irq_d;
  logic                    ovr_q, ovr_d;

  logic                    tick;
  logic                    expiry;
  logic                    zero_load;
  logic                    event_hit;

  // Decrement that saturates at zero so the countdown can never wrap.
  function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    psc_lim_d  = psc_lim_q;
    psc_cnt_d  = psc_cnt_q;
    periodic_d = periodic_q;
    irq_d      = irq_q;
    ovr_d      = ovr_q;
    tick       = 1'b0;
    expiry     = 1'b0;
    zero_load  = 1'b0;
    event_hit  = 1'b0;

    // Prescaler: one tick every (psc_lim_q+1) enabled cycles in RUN.
    if (state_q == ST_RUN && en_i) begin
      if (psc_cnt_q == psc_lim_q) begin
        tick      = 1'b1;
        psc_cnt_d = '0;
      end else begin
        psc_cnt_d = psc_cnt_q + PSC_ONE;
      end
    end

    if (tick) begin
      if (count_q > CNT_ONE) begin
        count_d = sat_dec(count_q);
      end else begin
        expiry = 1'b1;
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
    end

    // A load overrides whatever the tick logic decided on this edge,
    // including a coincident expiry.
    if (load_i) begin
      if (load_val_i != '0) begin
        count_d    = load_val_i;
        reload_d   = load_val_i;
        psc_cnt_d  = '0;
        psc_lim_d  = prescale_i;
        periodic_d = periodic_i;
        state_d    = ST_RUN;
      end else begin
        zero_load = 1'b1;
        psc_cnt_d = '0;
        state_d   = ST_IDLE;
        count_d   = (state_q == ST_RUN) ? '0 : count_q;
      end
    end

    event_hit = zero_load | (expiry & ~load_i);

    // A coincident ack retires the old event; the new one re-arms irq.
    if (event_hit) begin
      irq_d = 1'b1;
      ovr_d = ack_i ? 1'b0 : (ovr_q | irq_q);
    end else if (ack_i) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      psc_lim_q  <= '0;
      psc_cnt_q  <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      psc_lim_q  <= psc_lim_d;
      psc_cnt_q  <= psc_cnt_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
    end
  end

  assign count_o   = count_q;
  assign busy_o    = (state_q == ST_RUN);
  assign irq_o     = irq_q;
  assign overrun_o = ovr_q;

endmodule

// File: doc/iob_alarm_core.md
Name: iob_alarm_core

Overview:
- Programmable countdown alarm core. It is the event-generating counterpart of the free-running timer core: the timer measures elapsed time, this core produces an interrupt after a programmed time.
- Sits behind the peripheral CSR block. Software loads a cycle count, prescale and mode, then receives a sticky interrupt on expiry.
- Supports one-shot and periodic (auto-reload) operation, with overrun detection.

Parameters:
- DATA_W, 32, width of the countdown and reload registers.
- PRESCALE_W, 16, width of the prescaler divider.

Ports:
- clk_i  input  1  system clock.
- arst_n_i  input  1  reset, asynchronous, active-low.
- cke_i  input  1  clock enable. When 0, all state freezes.
- en_i  input  1  count enable. When 0, the countdown and prescaler pause.
- load_i  input  1  single-cycle strobe. Captures load_val_i, prescale_i and periodic_i, then (re)starts the alarm.
- load_val_i  input  DATA_W  number of prescaled ticks to expiry.
- prescale_i  input  PRESCALE_W  divider minus one. A value of 0 gives one tick per enabled cycle.
- periodic_i  input  1  1 selects auto-reload, 0 selects one-shot.
- ack_i  input  1  single-cycle strobe. Clears irq_o and overrun_o.
- count_o  output  DATA_W  current remaining ticks.
- busy_o  output  1  1 while in the RUN state.
- irq_o  output  1  sticky expiry flag.
- overrun_o  output  1  sticky flag: an expiry occurred while irq_o was still set.

Behaviour:
- Reset (arst_n_i=0, asynchronous): state IDLE; count_o=0; busy_o=0; irq_o=0; overrun_o=0; prescaler=0; reload register=0; mode=one-shot.
- All register updates are qualified by cke_i=1. When cke_i=0, nothing changes, including handling of load_i and ack_i.
- State IDLE:
  - count_o holds its value.
  - load_i with load_val_i!=0: count_o<=load_val_i, reload<=load_val_i, prescaler<=0, latch prescale and mode, go to RUN.
  - load_i with load_val_i==0: no RUN. irq_o set on the same edge (overrun rules apply). Stay IDLE.
- State RUN, tick generation:
  - Each edge with en_i=1 increments the prescaler.
  - When the prescaler equals the latched prescale, a tick occurs and the prescaler returns to 0.
  - en_i=0: no increment, no tick.
- State RUN, tick handling:
  - Tick with count_o>1: count_o decrements by 1.
  - Tick with count_o==1 (expiry): irq_o<=1.
    - One-shot: count_o<=0, go to IDLE.
    - Periodic: count_o<=reload, stay RUN.
- Timing: with prescale P and load value N, the expiry edge is (P+1)*N enabled edges after the load edge. irq_o is visible immediately after that edge. The period in periodic mode is exactly (P+1)*N enabled cycles, with no gap.
- Load while in RUN: restart immediately with the new values. Any tick on that edge is discarded. irq_o and overrun_o are unaffected.
- Expiry and load on the same edge: load wins, and the expiry is suppressed.
- Overrun: if an expiry (or a zero load) happens while irq_o=1 and ack_i=0, overrun_o<=1.
- Expiry and ack on the same edge: irq_o stays 1, overrun_o<=0. The ack clears the old event; the new event sets irq_o again.
- ack_i with no expiry on that edge: irq_o<=0, overrun_o<=0.
- busy_o = (state==RUN), registered.
- No arithmetic wrap: count_o never underflows below 0.

Test Plan:
- One-shot, no prescale: reset; en_i=1; load 10, prescale 0, periodic 0 -> count_o steps 10→1; irq_o rises exactly 10 edges after load; count_o=0, busy_o=0; irq_o holds until ack_i, then 0 after the next edge.
- Periodic with prescale: load 5, prescale 3, periodic 1, acking each event -> irq_o sets every 20 cycles over 4 periods; count_o reloads 1→5 with no gap; overrun_o stays 0.
- Overrun: periodic load 4, prescale 0, no ack -> irq_o set at edge 4; overrun_o set at edge 8; a single ack clears both. Ack coincident with expiry -> irq_o=1, overrun_o=0.
- Pause: load 8; drop en_i for 5 cycles mid-count -> count_o frozen; irq_o arrives 13 cycles after load. Holding cke_i=0 freezes everything, including ack.
- Reload and zero load: in RUN at count 3, load 20 -> count_o=20, expiry 20 edges later. Load 0 in IDLE -> irq_o=1 next edge, busy_o stays 0.
- Async reset mid-run: assert arst_n_i=0 between edges while counting with irq_o=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
